sfifo_wconv_prefetch: RTL and testbench

//  Single-clock prefetch (first-word-fall-through) FIFO with parametrised width conversion
//  in either direction (wide-in/narrow-out or narrow-in/wide-out).

---
 rtl/sfifo_wconv_prefetch.sv | 131 +++++++++++++
 tb/tb_sfifo_wconv_prefetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_wconv_prefetch.sv
// Single-clock first-word-fall-through FIFO with width conversion in either direction.
// Storage words are max(WR,RD) bits wide; narrow writes are packed and wide words unpacked LSB-first.
module sfifo_wconv_prefetch #(
    parameter int WR_DATA_WIDTH = 64,
    parameter int RD_DATA_WIDTH = 16,
    parameter int DEPTH_WIDTH   = 7,
    parameter int AFULL_TH      = 120,
    parameter int AEMPTY_TH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    output logic                     wr_vld,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH_WIDTH:0]     level,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int SW    = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int R_IN  = (RD_DATA_WIDTH > WR_DATA_WIDTH) ? RD_DATA_WIDTH / WR_DATA_WIDTH : 1;
    localparam int R_OUT = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH / RD_DATA_WIDTH : 1;
    localparam int CAP   = 1 << DEPTH_WIDTH;
    localparam int IW    = 4;

    logic [SW-1:0]            mem [CAP];
    logic [SW-1:0]            pack_q, pack_d, wr_word;
    logic [IW-1:0]            pcnt_q, pcnt_d, idx_q, idx_d;
    logic [DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]     ram_cnt_q, ram_cnt_d, level_q, level_d;
    logic                     s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
    logic [SW-1:0]            s1_data_q, out_word_q, out_word_d;
    logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                     wr_vld_q, wr_vld_d, afull_q, afull_d, aempty_q, aempty_d;
    logic                     wr_acc, word_done, pop, retire, out_free, s1_move, ram_rd;

    always_comb begin
        wr_acc    = wr_en & wr_vld_q & ~flush;
        word_done = wr_acc & (pcnt_q == IW'(R_IN - 1));
        pop       = rd_en & out_vld_q & ~flush;
        retire    = pop & (idx_q == IW'(R_OUT - 1));
        // Prefetch stages advance whenever the stage ahead is empty or draining this cycle.
        out_free  = ~out_vld_q | retire;
        s1_move   = s1_vld_q & out_free;
        ram_rd    = (ram_cnt_q != '0) & (~s1_vld_q | s1_move);
        wr_word   = (pack_q >> WR_DATA_WIDTH) | (SW'(wr_data) << (SW - WR_DATA_WIDTH));

        pack_d     = wr_acc ? wr_word : pack_q;
        pcnt_d     = word_done ? '0 : (wr_acc ? pcnt_q + IW'(1) : pcnt_q);
        wr_ptr_d   = wr_ptr_q + DEPTH_WIDTH'(word_done);
        rd_ptr_d   = rd_ptr_q + DEPTH_WIDTH'(ram_rd);
        ram_cnt_d  = ram_cnt_q + (DEPTH_WIDTH+1)'(word_done) - (DEPTH_WIDTH+1)'(ram_rd);
        level_d    = level_q + (DEPTH_WIDTH+1)'(word_done) - (DEPTH_WIDTH+1)'(retire);
        s1_vld_d   = ram_rd ? 1'b1 : (s1_move ? 1'b0 : s1_vld_q);
        out_vld_d  = s1_move ? 1'b1 : (retire ? 1'b0 : out_vld_q);
        out_word_d = s1_move ? s1_data_q : out_word_q;
        idx_d      = retire ? '0 : (pop ? idx_q + IW'(1) : idx_q);
        rd_data_d  = out_vld_d ? RD_DATA_WIDTH'(out_word_d >> (RD_DATA_WIDTH * int'(idx_d)))
                               : rd_data_q;

        if (flush) begin
            pack_d     = '0;
            pcnt_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            level_d    = '0;
            s1_vld_d   = 1'b0;
            out_vld_d  = 1'b0;
            out_word_d = '0;
            idx_d      = '0;
            rd_data_d  = '0;
        end

        wr_vld_d = level_d < (DEPTH_WIDTH+1)'(CAP);
        afull_d  = int'(level_d) >= AFULL_TH;
        aempty_d = int'(level_d) <= AEMPTY_TH;
    end

    // Data path storage is not reset; pointers and valid flags alone define what is held.
    always_ff @(posedge clk) begin
        if (word_done) mem[wr_ptr_q] <= wr_word;
        if (ram_rd)    s1_data_q     <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_q     <= '0;
            pcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            level_q    <= '0;
            s1_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_word_q <= '0;
            idx_q      <= '0;
            rd_data_q  <= '0;
            wr_vld_q   <= 1'b0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
        end else begin
            pack_q     <= pack_d;
            pcnt_q     <= pcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            level_q    <= level_d;
            s1_vld_q   <= s1_vld_d;
            out_vld_q  <= out_vld_d;
            out_word_q <= out_word_d;
            idx_q      <= idx_d;
            rd_data_q  <= rd_data_d;
            wr_vld_q   <= wr_vld_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
        end
    end

    assign wr_vld       = wr_vld_q;
    assign rd_vld       = out_vld_q;
    assign rd_data      = rd_data_q;
    assign level        = level_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_sfifo_wconv_prefetch.sv
// Randomized bench for two FIFO instances (64->16 and 16->64, 16 words deep) against a
// queue-level reference model: a storage word becomes readable two edges after it completes.
module tb_sfifo_wconv_prefetch;

    localparam int DW  = 4;
    localparam int CAP = 16;
    localparam int AF  = 14;
    localparam int AE  = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        wr_en0, rd_en0, wr_vld0, rd_vld0, af0, ae0;
    logic [63:0] wr_data0;
    logic [15:0] rd_data0;
    logic [4:0]  level0;
    logic        wr_en1, rd_en1, wr_vld1, rd_vld1, af1, ae1;
    logic [15:0] wr_data1;
    logic [63:0] rd_data1;
    logic [4:0]  level1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [63:0] m_data [2][32];
    int          m_time [2][32];
    int          m_head [2], m_count [2], m_idx [2], m_pcnt [2];
    logic [63:0] m_pend [2], m_last [2];
    bit          m_wr_vld [2], m_rd_vld [2];

    sfifo_wconv_prefetch #(.WR_DATA_WIDTH(64), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(DW),
                           .AFULL_TH(AF), .AEMPTY_TH(AE)) u_w2n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en0), .wr_vld(wr_vld0),
        .wr_data(wr_data0), .rd_en(rd_en0), .rd_vld(rd_vld0), .rd_data(rd_data0),
        .level(level0), .almost_full(af0), .almost_empty(ae0));

    sfifo_wconv_prefetch #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(64), .DEPTH_WIDTH(DW),
                           .AFULL_TH(AF), .AEMPTY_TH(AE)) u_n2w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en1), .wr_vld(wr_vld1),
        .wr_data(wr_data1), .rd_en(rd_en1), .rd_vld(rd_vld1), .rd_data(rd_data1),
        .level(level1), .almost_full(af1), .almost_empty(ae1));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear(input int d);
        m_head[d]  = 0;
        m_count[d] = 0;
        m_idx[d]   = 0;
        m_pcnt[d]  = 0;
        m_pend[d]  = '0;
        m_last[d]  = '0;
    endtask

    // Stream-level model: pieces accumulate into words, words queue, slices pop LSB-first.
    task automatic model_edge(input int d, input bit w, input bit r, input logic [63:0] wd);
        int ww, rw, r_in, r_out;
        logic [63:0] rmask, wmask;
        bit wacc, racc;
        ww    = (d == 0) ? 64 : 16;
        rw    = (d == 0) ? 16 : 64;
        r_in  = (d == 0) ? 1 : 4;
        r_out = (d == 0) ? 4 : 1;
        wmask = (ww == 64) ? '1 : ((64'd1 << ww) - 64'd1);
        rmask = (rw == 64) ? '1 : ((64'd1 << rw) - 64'd1);
        if (!rst_n) begin
            model_clear(d);
            m_wr_vld[d] = 1'b0;
        end else if (flush) begin
            model_clear(d);
            m_wr_vld[d] = 1'b1;
        end else begin
            wacc = w && m_wr_vld[d];
            racc = r && m_rd_vld[d];
            if (racc) begin
                m_idx[d]++;
                if (m_idx[d] == r_out) begin
                    m_idx[d]   = 0;
                    m_head[d]  = (m_head[d] + 1) % 32;
                    m_count[d]--;
                end
            end
            if (wacc) begin
                m_pend[d] = m_pend[d] | ((wd & wmask) << (ww * m_pcnt[d]));
                m_pcnt[d]++;
                if (m_pcnt[d] == r_in) begin
                    m_data[d][(m_head[d] + m_count[d]) % 32] = m_pend[d];
                    m_time[d][(m_head[d] + m_count[d]) % 32] = cyc;
                    m_count[d]++;
                    m_pend[d] = '0;
                    m_pcnt[d] = 0;
                end
            end
            m_wr_vld[d] = (m_count[d] < CAP);
        end
        m_rd_vld[d] = (m_count[d] > 0) && (m_time[d][m_head[d]] + 2 <= cyc);
        if (m_rd_vld[d])
            m_last[d] = (m_data[d][m_head[d]] >> (rw * m_idx[d])) & rmask;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0, wr_en0, rd_en0, wr_data0);
        model_edge(1, wr_en1, rd_en1, 64'(wr_data1));
        #1;
        checkOutput("w2n.wr_vld",  64'(wr_vld0), 64'(m_wr_vld[0]));
        checkOutput("w2n.rd_vld",  64'(rd_vld0), 64'(m_rd_vld[0]));
        checkOutput("w2n.rd_data", 64'(rd_data0), m_last[0]);
        checkOutput("w2n.level",   64'(level0), 64'(m_count[0]));
        checkOutput("w2n.afull",   64'(af0), 64'(m_count[0] >= AF));
        checkOutput("w2n.aempty",  64'(ae0), 64'(m_count[0] <= AE));
        checkOutput("n2w.wr_vld",  64'(wr_vld1), 64'(m_wr_vld[1]));
        checkOutput("n2w.rd_vld",  64'(rd_vld1), 64'(m_rd_vld[1]));
        checkOutput("n2w.rd_data", rd_data1, m_last[1]);
        checkOutput("n2w.level",   64'(level1), 64'(m_count[1]));
        checkOutput("n2w.afull",   64'(af1), 64'(m_count[1] >= AF));
        checkOutput("n2w.aempty",  64'(ae1), 64'(m_count[1] <= AE));
    endtask

    task automatic applyStimulus(input int n, input int wp0, input int rp0,
                                 input int wp1, input int rp1);
        repeat (n) begin
            wr_en0   = ($urandom_range(99) < wp0);
            rd_en0   = ($urandom_range(99) < rp0);
            wr_en1   = ($urandom_range(99) < wp1);
            rd_en1   = ($urandom_range(99) < rp1);
            wr_data0 = {$urandom, $urandom};
            wr_data1 = 16'($urandom);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
        wr_data0 = '0; wr_data1 = '0;
        model_clear(0); model_clear(1);
        m_wr_vld[0] = 1'b0; m_wr_vld[1] = 1'b0;
        m_rd_vld[0] = 1'b0; m_rd_vld[1] = 1'b0;
        tick(); tick();
        checkOutput("reset.aempty", 64'(ae0), 64'd1);
        checkOutput("reset.wr_vld", 64'(wr_vld1), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("wr_vld_rise", 64'(wr_vld0), 64'd1);

        wr_en0 = 1'b1; wr_data0 = 64'h4444_3333_2222_1111;
        wr_en1 = 1'b1; wr_data1 = 16'h000A;
        tick();
        wr_en0 = 1'b0; wr_data1 = 16'h000B;
        tick();
        wr_data1 = 16'h000C;
        tick();
        checkOutput("t1.rd_vld", 64'(rd_vld0), 64'd1);
        checkOutput("t1.first", 64'(rd_data0), 64'h1111);
        wr_data1 = 16'h000D;
        tick();
        wr_en1 = 1'b0;
        tick();
        checkOutput("t2.early", 64'(rd_vld1), 64'd0);
        tick();
        checkOutput("t2.word", rd_data1, 64'h000D_000C_000B_000A);
        rd_en0 = 1'b1; rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        checkOutput("t1.second", 64'(rd_data0), 64'h2222);
        tick(); tick(); tick();
        rd_en0 = 1'b0;
        checkOutput("t1.drained", 64'(rd_vld0), 64'd0);
        checkOutput("t1.level", 64'(level0), 64'd0);
        checkOutput("t1.hold", 64'(rd_data0), 64'h4444);

        wr_en1 = 1'b1;
        repeat (3) begin
            wr_data1 = 16'($urandom);
            tick();
        end
        wr_en1 = 1'b0;
        tick(); tick(); tick();
        checkOutput("t2.partial_vld", 64'(rd_vld1), 64'd0);
        checkOutput("t2.partial_lvl", 64'(level1), 64'd0);

        applyStimulus(40, 100, 0, 100, 0);
        checkOutput("t3.wr_vld", 64'(wr_vld0), 64'd0);
        checkOutput("t3.level", 64'(level0), 64'd16);
        checkOutput("t3.afull", 64'(af0), 64'd1);
        applyStimulus(80, 0, 100, 0, 100);
        applyStimulus(1000, 25, 100, 100, 25);
        applyStimulus(500, 50, 50, 60, 30);

        applyStimulus(20, 60, 40, 70, 20);
        wr_en0 = 1'b1; rd_en0 = 1'b1; wr_en1 = 1'b1; rd_en1 = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t5.level", 64'(level0), 64'd0);
        checkOutput("t5.rd_vld", 64'(rd_vld1), 64'd0);
        checkOutput("t5.wr_vld", 64'(wr_vld1), 64'd1);
        applyStimulus(200, 40, 70, 80, 30);

        applyStimulus(30, 70, 20, 70, 20);
        wr_en1 = 1'b1; wr_data1 = 16'h5A5A;
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("t6.level", 64'(level1), 64'd0);
        checkOutput("t6.rd_data", rd_data1, 64'd0);
        rst_n = 1'b1;
        applyStimulus(300, 50, 50, 50, 50);
        applyStimulus(100, 0, 100, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
